noc_input_unit: RTL and testbench

- Per-port input stage of the NoC router; five instances per router, one per noc_port_t.
- Buffers incoming flits in a PortQueueDepth-entry FIFO and computes the XY route for each head flit.
- Holds that route for the packet's body and tail (wormhole), and presents flit plus one-hot direction_t to the switch allocator/crossbar downstream.
- Returns flow control upstream, either credit-based or ack/nack stop.

---
 rtl/noc_input_unit_pkg.sv | 75 +++++++
 rtl/noc_fifo.sv | 57 +++++
 rtl/noc_input_unit.sv | 151 +++++++++++++++
 tb/tb_noc_input_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_input_unit_pkg.sv
// Shared NoC types: ports, directions, coordinates, flit header layout and XY routing helper.
package noc_input_unit_pkg;

    typedef enum logic [2:0] {
        kLocalPort = 3'd0,
        kEastPort  = 3'd1,
        kWestPort  = 3'd2,
        kSouthPort = 3'd3,
        kNorthPort = 3'd4
    } noc_port_t;

    typedef enum logic {
        kFlowControlCreditBased = 1'b0,
        kFlowControlAckNack     = 1'b1
    } noc_flow_control_t;

    typedef struct packed {
        logic go_local;
        logic go_east;
        logic go_west;
        logic go_south;
        logic go_north;
    } direction_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } xy_t;

    typedef struct packed {
        logic head;
        logic tail;
    } preamble_t;

    typedef logic [3:0] message_t;

    typedef struct packed {
        preamble_t preamble;
        xy_t       src;
        xy_t       dst;
        message_t  msg;
    } header_t;

    localparam int DefaultFlitWidth = 64;
    localparam int PortQueueDepth   = 5;
    localparam int CreditsWidth     = $clog2(PortQueueDepth + 1);
    localparam direction_t AllPorts = direction_t'(5'b11111);

    function automatic direction_t get_onehot_port(input noc_port_t port);
        direction_t dir;
        dir = '0;
        case (port)
            kLocalPort: dir.go_local = 1'b1;
            kEastPort:  dir.go_east  = 1'b1;
            kWestPort:  dir.go_west  = 1'b1;
            kSouthPort: dir.go_south = 1'b1;
            kNorthPort: dir.go_north = 1'b1;
            default:    dir = '0;
        endcase
        return dir;
    endfunction

    // Dimension-ordered routing: resolve X completely before moving in Y.
    function automatic direction_t xy_route(input xy_t position, input xy_t dst);
        direction_t dir;
        dir = '0;
        if (dst.x > position.x)      dir.go_east  = 1'b1;
        else if (dst.x < position.x) dir.go_west  = 1'b1;
        else if (dst.y > position.y) dir.go_south = 1'b1;
        else if (dst.y < position.y) dir.go_north = 1'b1;
        else                         dir.go_local = 1'b1;
        return dir;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO with occupancy count; depth need not be a power of two.
module noc_fifo #(
    parameter int Depth = 5,
    parameter int Width = 64,
    localparam int CountWidth = $clog2(Depth + 1),
    localparam int PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [Width-1:0]      wdata,
    output logic [Width-1:0]      rdata,
    output logic [CountWidth-1:0] count,
    output logic                  full,
    output logic                  empty
);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic                push_ok;
    logic                pop_ok;

    function automatic logic [PtrWidth-1:0] wrap_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
    endfunction

    assign full    = (count == CountWidth'(Depth));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is not reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wrap_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= wrap_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CountWidth'(1);
                2'b01:   count <= count - CountWidth'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_input_unit.sv
// NoC router input port: flit queue, wormhole XY route hold, credit or ack/nack flow control.
// Optional sticky illegal-route detection is built when NOC_INPUT_ROUTE_CHECK_EN is defined.
module noc_input_unit
    import noc_input_unit_pkg::*;
#(
    parameter int                FlitWidth   = DefaultFlitWidth,
    parameter noc_flow_control_t FlowControl = kFlowControlCreditBased,
    parameter noc_port_t         ThisPort    = kNorthPort,
    parameter direction_t        PortsEnable = AllPorts
) (
    input  logic                 clk,
    input  logic                 rst,
    input  xy_t                  position,
    input  logic [FlitWidth-1:0] data_in,
    input  logic                 data_void_in,
    output logic                 stop_out,
    output logic                 credit_out,
    output logic [FlitWidth-1:0] data_out,
    output logic                 data_void_out,
    output direction_t           route_out,
    input  logic                 grant_in,
    output logic                 error_out
);

    typedef enum logic {IDLE, ROUTED} route_state_t;

    // Header fields are sliced from the flit MSBs in header_t order.
    localparam int DstLsb = FlitWidth - $bits(header_t) + $bits(message_t);

    if ((PortsEnable & get_onehot_port(ThisPort)) == '0) begin : g_port_disabled
        $error("noc_input_unit instantiated for a port that PortsEnable disables");
    end

    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CreditsWidth-1:0] count;
    logic [CreditsWidth-1:0] count_next;
    logic                    stop_q;
    logic                    credit_q;
    preamble_t               head_preamble;
    xy_t                     head_dst;
    direction_t              computed_route;
    direction_t              route_q;
    logic                    latch_route;
    route_state_t            state_q;
    route_state_t            state_d;

    assign push = !data_void_in;
    assign pop  = grant_in && !fifo_empty;

    noc_fifo #(
        .Depth (PortQueueDepth),
        .Width (FlitWidth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (data_in),
        .rdata (data_out),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign data_void_out  = fifo_empty;
    assign head_preamble  = preamble_t'(data_out[FlitWidth-1 -: $bits(preamble_t)]);
    assign head_dst       = xy_t'(data_out[DstLsb +: $bits(xy_t)]);
    assign computed_route = xy_route(position, head_dst);
    assign count_next     = count + CreditsWidth'(push && (!fifo_full || pop)) - CreditsWidth'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_q   <= 1'b0;
            credit_q <= 1'b0;
        end else begin
            // Threshold one below depth leaves room for the flit already in flight.
            stop_q   <= (count_next >= CreditsWidth'(PortQueueDepth - 1));
            credit_q <= pop;
        end
    end

    assign stop_out   = (FlowControl == kFlowControlAckNack)     ? stop_q   : 1'b0;
    assign credit_out = (FlowControl == kFlowControlCreditBased) ? credit_q : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_route) route_q <= computed_route;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        latch_route = 1'b0;
        if (pop) begin
            case (state_q)
                IDLE: begin
                    if (head_preamble.head && !head_preamble.tail) begin
                        state_d     = ROUTED;
                        latch_route = 1'b1;
                    end
                end
                ROUTED: begin
                    if (head_preamble.tail) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        route_out = '0;
        if (!fifo_empty) route_out = (state_q == ROUTED) ? route_q : computed_route;
    end

`ifdef NOC_INPUT_ROUTE_CHECK_EN
    localparam direction_t UturnMask =
        (ThisPort == kLocalPort) ? direction_t'('0) : get_onehot_port(ThisPort);

    logic error_q;
    logic route_illegal;

    assign route_illegal = !fifo_empty &&
                           ((|(route_out & UturnMask)) || (|(route_out & ~PortsEnable)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                error_q <= 1'b0;
        else if (route_illegal) error_q <= 1'b1;
    end

    assign error_out = error_q;
`else
    assign error_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (FlowControl == kFlowControlCreditBased) assert (!(push && fifo_full && !pop));
            assert (!(grant_in && fifo_empty));
            if (pop) assert ((state_q == ROUTED) ? !head_preamble.head : head_preamble.head);
        end
    end

endmodule

// File: tb/tb_noc_input_unit.sv
// Directed bench for noc_input_unit: credit and ack/nack instances, plus a route-check instance
// when NOC_INPUT_ROUTE_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_noc_input_unit;
    import noc_input_unit_pkg::*;

    localparam int W = 64;
    localparam logic [4:0] GO_LOCAL = 5'b10000;
    localparam logic [4:0] GO_EAST  = 5'b01000;
    localparam logic [4:0] GO_WEST  = 5'b00100;
    localparam logic [4:0] GO_SOUTH = 5'b00010;
    localparam logic [4:0] GO_NORTH = 5'b00001;
    localparam logic [4:0] GO_NONE  = 5'b00000;

    logic       clk = 1'b0;
    logic       rst;
    xy_t        position;

    logic [W-1:0] cr_din, cr_dout, an_din, an_dout;
    logic         cr_void_in, cr_void_out, cr_grant, cr_stop, cr_credit, cr_error;
    logic         an_void_in, an_void_out, an_grant, an_stop, an_credit, an_error;
    direction_t   cr_route, an_route;

    int n_cmp = 0;
    int n_bad = 0;
    int cr_credits = 0;

    always #5 clk = ~clk;

    noc_input_unit #(
        .FlitWidth (W), .FlowControl (kFlowControlCreditBased),
        .ThisPort (kLocalPort), .PortsEnable (AllPorts)
    ) u_dut_cr (
        .clk (clk), .rst (rst), .position (position),
        .data_in (cr_din), .data_void_in (cr_void_in),
        .stop_out (cr_stop), .credit_out (cr_credit),
        .data_out (cr_dout), .data_void_out (cr_void_out),
        .route_out (cr_route), .grant_in (cr_grant), .error_out (cr_error)
    );

    noc_input_unit #(
        .FlitWidth (W), .FlowControl (kFlowControlAckNack),
        .ThisPort (kLocalPort), .PortsEnable (AllPorts)
    ) u_dut_an (
        .clk (clk), .rst (rst), .position (position),
        .data_in (an_din), .data_void_in (an_void_in),
        .stop_out (an_stop), .credit_out (an_credit),
        .data_out (an_dout), .data_void_out (an_void_out),
        .route_out (an_route), .grant_in (an_grant), .error_out (an_error)
    );

`ifdef NOC_INPUT_ROUTE_CHECK_EN
    logic [W-1:0] ck_din, ck_dout;
    logic         ck_void_in, ck_void_out, ck_grant, ck_stop, ck_credit, ck_error;
    direction_t   ck_route;

    noc_input_unit #(
        .FlitWidth (W), .FlowControl (kFlowControlCreditBased),
        .ThisPort (kEastPort), .PortsEnable (AllPorts)
    ) u_dut_ck (
        .clk (clk), .rst (rst), .position (position),
        .data_in (ck_din), .data_void_in (ck_void_in),
        .stop_out (ck_stop), .credit_out (ck_credit),
        .data_out (ck_dout), .data_void_out (ck_void_out),
        .route_out (ck_route), .grant_in (ck_grant), .error_out (ck_error)
    );
`endif

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (cr_credit) cr_credits++;
    endtask

    function automatic logic [W-1:0] make_flit(input logic head, input logic tail,
                                               input int dx, input int dy, input logic [7:0] tag);
        header_t      h;
        logic [W-1:0] f;
        h.preamble.head = head;
        h.preamble.tail = tail;
        h.src.x = 4'd2;
        h.src.y = 4'd2;
        h.dst.x = 4'(dx);
        h.dst.y = 4'(dy);
        h.msg   = 4'h3;
        f = '0;
        f[W-1 -: $bits(header_t)] = h;
        f[7:0] = tag;
        return f;
    endfunction

    typedef struct packed {
        logic [3:0] dx;
        logic [3:0] dy;
        logic [4:0] route;
    } route_vec_t;

    typedef struct packed {
        logic [W-1:0] flit;
        logic [4:0]   route;
    } drain_vec_t;

    route_vec_t   vecs  [8];
    drain_vec_t   drain [5];
    logic [W-1:0] pkt   [4];
    logic [W-1:0] q     [6];
    logic [W-1:0] flit;

    initial begin
        // Single-flit packets from router (2,2): X resolved before Y.
        vecs[0] = '{4'd5, 4'd1, GO_EAST};
        vecs[1] = '{4'd0, 4'd3, GO_WEST};
        vecs[2] = '{4'd2, 4'd4, GO_SOUTH};
        vecs[3] = '{4'd2, 4'd0, GO_NORTH};
        vecs[4] = '{4'd2, 4'd2, GO_LOCAL};
        vecs[5] = '{4'd3, 4'd0, GO_EAST};
        vecs[6] = '{4'd1, 4'd7, GO_WEST};
        vecs[7] = '{4'd2, 4'd3, GO_SOUTH};

        rst = 1'b1;
        position.x = 4'd2;
        position.y = 4'd2;
        cr_din = '0; cr_void_in = 1'b1; cr_grant = 1'b0;
        an_din = '0; an_void_in = 1'b1; an_grant = 1'b0;
`ifdef NOC_INPUT_ROUTE_CHECK_EN
        ck_din = '0; ck_void_in = 1'b1; ck_grant = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst_void",   64'(cr_void_out), 64'(1'b1));
        check("rst_route",  64'(cr_route),    64'(GO_NONE));
        check("rst_credit", 64'(cr_credit),   64'(1'b0));
        check("rst_stop",   64'(an_stop),     64'(1'b0));
        check("rst_error",  64'(cr_error),    64'(1'b0));
        check("rst_an_void", 64'(an_void_out), 64'(1'b1));

        for (int i = 0; i < 8; i++) begin
            flit = make_flit(1'b1, 1'b1, int'(vecs[i].dx), int'(vecs[i].dy), 8'(i));
            cr_din = flit;
            cr_void_in = 1'b0;
            tick();
            cr_void_in = 1'b1;
            check("vec_void",  64'(cr_void_out), 64'(1'b0));
            check("vec_data",  cr_dout, flit);
            check("vec_route", 64'(cr_route), 64'(vecs[i].route));
            cr_credits = 0;
            cr_grant = 1'b1;
            tick();
            cr_grant = 1'b0;
            check("vec_credit_pulse", 64'(cr_credits), 64'(1));
            check("vec_empty_route",  64'(cr_route),   64'(GO_NONE));
            tick();
            check("vec_credit_low", 64'(cr_credit), 64'(1'b0));
        end

        // Wormhole: body/tail carry a misleading dst to prove the head's route is held.
        pkt[0] = make_flit(1'b1, 1'b0, 2, 0, 8'h20);
        pkt[1] = make_flit(1'b0, 1'b0, 7, 7, 8'h21);
        pkt[2] = make_flit(1'b0, 1'b0, 7, 7, 8'h22);
        pkt[3] = make_flit(1'b0, 1'b1, 7, 7, 8'h23);
        for (int i = 0; i < 4; i++) begin
            cr_din = pkt[i];
            cr_void_in = 1'b0;
            tick();
        end
        cr_void_in = 1'b1;
        for (int s = 0; s < 3; s++) begin
            check("stall_route", 64'(cr_route), 64'(GO_NORTH));
            check("stall_data",  cr_dout, pkt[0]);
            tick();
        end
        cr_credits = 0;
        for (int i = 0; i < 4; i++) begin
            check("worm_data",  cr_dout, pkt[i]);
            check("worm_route", 64'(cr_route), 64'(GO_NORTH));
            cr_grant = 1'b1;
            tick();
        end
        cr_grant = 1'b0;
        check("worm_empty",   64'(cr_void_out), 64'(1'b1));
        check("worm_credits", 64'(cr_credits),  64'(4));

        // Back-to-back packets fill the queue, then push+grant while full.
        drain[0] = '{make_flit(1'b0, 1'b0, 0, 0, 8'h31), GO_LOCAL};
        drain[1] = '{make_flit(1'b0, 1'b1, 0, 0, 8'h32), GO_LOCAL};
        drain[2] = '{make_flit(1'b1, 1'b0, 0, 2, 8'h33), GO_WEST};
        drain[3] = '{make_flit(1'b0, 1'b1, 4, 4, 8'h34), GO_WEST};
        drain[4] = '{make_flit(1'b1, 1'b1, 2, 4, 8'h35), GO_SOUTH};
        flit = make_flit(1'b1, 1'b0, 2, 2, 8'h30);
        cr_din = flit;
        cr_void_in = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            cr_din = drain[i].flit;
            tick();
        end
        cr_void_in = 1'b1;
        check("full_count",      64'(u_dut_cr.u_fifo.count), 64'(5));
        check("full_stop_tied",  64'(cr_stop),  64'(1'b0));
        check("full_head_route", 64'(cr_route), 64'(GO_LOCAL));
        check("full_head_data",  cr_dout, flit);
        cr_credits = 0;
        cr_din = drain[4].flit;
        cr_void_in = 1'b0;
        cr_grant = 1'b1;
        tick();
        cr_void_in = 1'b1;
        cr_grant = 1'b0;
        check("pushpop_count",  64'(u_dut_cr.u_fifo.count), 64'(5));
        check("pushpop_credit", 64'(cr_credits), 64'(1));
        tick();
        check("pushpop_credit_once", 64'(cr_credits), 64'(1));
        cr_credits = 0;
        for (int i = 0; i < 5; i++) begin
            check("b2b_data",  cr_dout, drain[i].flit);
            check("b2b_route", 64'(cr_route), 64'(drain[i].route));
            cr_grant = 1'b1;
            tick();
        end
        cr_grant = 1'b0;
        tick();
        check("b2b_credits", 64'(cr_credits),  64'(5));
        check("b2b_empty",   64'(cr_void_out), 64'(1'b1));
        check("cr_error_quiet", 64'(cr_error), 64'(1'b0));

        // Ack/nack: stop asserts once four entries are held; the in-flight fifth still fits.
        for (int i = 0; i < 6; i++) q[i] = make_flit(1'b1, 1'b1, 2, 0, 8'(8'h40 + i));
        for (int i = 0; i < 4; i++) begin
            an_din = q[i];
            an_void_in = 1'b0;
            tick();
            check("an_stop_fill", 64'(an_stop), 64'(i == 3));
        end
        an_void_in = 1'b1;
        an_grant = 1'b1;
        tick();
        an_grant = 1'b0;
        check("an_stop_release", 64'(an_stop),   64'(1'b0));
        check("an_credit_tied",  64'(an_credit), 64'(1'b0));
        an_din = q[4];
        an_void_in = 1'b0;
        tick();
        check("an_stop_again", 64'(an_stop), 64'(1'b1));
        an_din = q[5];
        tick();
        an_void_in = 1'b1;
        check("an_stop_inflight", 64'(an_stop), 64'(1'b1));
        for (int i = 1; i < 6; i++) begin
            check("an_drain_data",  an_dout, q[i]);
            check("an_drain_route", 64'(an_route), 64'(GO_NORTH));
            an_grant = 1'b1;
            tick();
        end
        an_grant = 1'b0;
        check("an_empty",    64'(an_void_out), 64'(1'b1));
        check("an_stop_end", 64'(an_stop),     64'(1'b0));
        check("an_error_quiet", 64'(an_error), 64'(1'b0));

`ifdef NOC_INPUT_ROUTE_CHECK_EN
        // East input port routing a flit back east is a U-turn.
        check("ck_error_init", 64'(ck_error), 64'(1'b0));
        flit = make_flit(1'b1, 1'b1, 5, 2, 8'h50);
        ck_din = flit;
        ck_void_in = 1'b0;
        tick();
        ck_void_in = 1'b1;
        check("ck_route", 64'(ck_route), 64'(GO_EAST));
        tick();
        check("ck_error_set", 64'(ck_error), 64'(1'b1));
        check("ck_data_kept", ck_dout, flit);
        ck_grant = 1'b1;
        tick();
        ck_grant = 1'b0;
        check("ck_delivered", 64'(ck_void_out), 64'(1'b1));
        tick();
        check("ck_error_sticky", 64'(ck_error), 64'(1'b1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("ck_error_cleared", 64'(ck_error), 64'(1'b0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
